// File: rtl/lane_mem_serdes_pkg.sv
// Shared constants and types for the lane <-> data-memory serial/parallel bridge.
package lane_mem_serdes_pkg;

   // Lane subword geometry
   localparam int P_NBITS   = 4;
   localparam int C_N_OFF   = 32 / P_NBITS;
   localparam int C_OFFBITS = $clog2(C_N_OFF);

   localparam logic [C_OFFBITS-1:0] C_CNT_LAST = C_OFFBITS'(C_N_OFF - 1);

   // funct3 load/store width encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Data-memory request length encodings
   localparam logic [1:0] LEN_W = 2'd0;
   localparam logic [1:0] LEN_B = 2'd1;
   localparam logic [1:0] LEN_H = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATHER,
      S_REQ,
      S_WAIT,
      S_SCATTER
   } state_e;

   // Memory request length for a funct3 access width
   function automatic logic [1:0] dmem_len(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: dmem_len = LEN_B;
         F3_H, F3_HU: dmem_len = LEN_H;
         default:     dmem_len = LEN_W;
      endcase
   endfunction

endpackage

// File: rtl/lane_load_align.sv
// Aligns a load response to the byte address and applies sign/zero extension.
module lane_load_align
   import lane_mem_serdes_pkg::*;
(
   input  logic [31:0] resp_data,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  ld_type,
   output logic [31:0] ld_data
);

   logic [15:0] shifted_lo;

   // Shift the addressed byte/half down to bit 0, then extend per access type
   always_comb begin
      shifted_lo = 16'(resp_data >> {addr_lo, 3'b000});
      ld_data    = resp_data;
      case (ld_type)
         F3_B:    ld_data = {{24{shifted_lo[7]}}, shifted_lo[7:0]};
         F3_BU:   ld_data = {24'b0, shifted_lo[7:0]};
         F3_H:    ld_data = {{16{shifted_lo[15]}}, shifted_lo};
         F3_HU:   ld_data = {16'b0, shifted_lo};
         default: ld_data = resp_data;
      endcase
   end

endmodule

// File: rtl/lane_mem_serdes.sv
// Bridges a 4-bit SIMD lane to the 32-bit data-memory port: gathers store
// nibbles into a word, issues the request, and scatters load data back.
module lane_mem_serdes
   import lane_mem_serdes_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_start_Xhl,
   input  logic                 req_is_store_Xhl,
   input  logic [2:0]           req_type_Xhl,
   input  logic [31:0]          req_addr_Xhl,
   input  logic [4:0]           req_rd_Xhl,
   input  logic                 st_nib_val_Xhl,
   input  logic [P_NBITS-1:0]   st_nib_Xhl,
   output logic                 dmemreq_val,
   input  logic                 dmemreq_rdy,
   output logic                 dmemreq_msg_rw,
   output logic [31:0]          dmemreq_msg_addr,
   output logic [1:0]           dmemreq_msg_len,
   output logic [31:0]          dmemreq_msg_data,
   input  logic                 dmemresp_val,
   output logic                 dmemresp_rdy,
   input  logic [31:0]          dmemresp_msg_data,
   output logic                 wb_en_Xhl,
   output logic [4:0]           wb_addr_Xhl,
   output logic [C_OFFBITS-1:0] wb_subword_off_Xhl,
   output logic [P_NBITS-1:0]   wb_data_Xhl,
   output logic                 busy,
   output logic                 done
);

   state_e               state_q, state_d;
   logic [C_OFFBITS-1:0] cnt_q, cnt_d;
   logic                 is_store_q, is_store_d;
   logic [2:0]           type_q, type_d;
   logic [31:0]          addr_q, addr_d;
   logic [4:0]           rd_q, rd_d;
   logic [31:0]          data_q, data_d;
   logic                 done_q, done_d;

   logic [31:0]          ld_data;
   logic [31:0]          st_data;

   lane_load_align u_align (
      .resp_data (dmemresp_msg_data),
      .addr_lo   (addr_q[1:0]),
      .ld_type   (type_q),
      .ld_data   (ld_data)
   );

   // Sub-word stores are placed on their byte lanes; full words go as gathered
   assign st_data = (type_q == F3_W) ? data_q : (data_q << {addr_q[1:0], 3'b000});

   // Next-state sequencing: latch request, gather, handshake, wait, scatter
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_store_d = is_store_q;
      type_d     = type_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      data_d     = data_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_start_Xhl) begin
               is_store_d = req_is_store_Xhl;
               type_d     = req_type_Xhl;
               addr_d     = req_addr_Xhl;
               rd_d       = req_rd_Xhl;
               cnt_d      = '0;
               state_d    = req_is_store_Xhl ? S_GATHER : S_REQ;
            end
         end
         S_GATHER: begin
            if (st_nib_val_Xhl) begin
               data_d[cnt_q*P_NBITS +: P_NBITS] = st_nib_Xhl;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == C_CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (dmemreq_rdy) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dmemresp_val) begin
               if (is_store_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  data_d  = ld_data;
                  cnt_d   = '0;
                  state_d = S_SCATTER;
               end
            end
         end
         S_SCATTER: begin
            cnt_d = cnt_q + 1'b1;
            // Registered done lines up with the last write-back nibble
            if (cnt_q == C_CNT_LAST - 1'b1) done_d = 1'b1;
            if (cnt_q == C_CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop updates from the same pre-edge values.
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_store_q <= 1'b0;
         type_q     <= '0;
         addr_q     <= '0;
         rd_q       <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_store_q <= is_store_d;
         type_q     <= type_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         done_q     <= done_d;
      end
   end

   // Outputs decode registered state only; request fields are zero outside REQ
   always_comb begin
      busy               = (state_q != S_IDLE);
      done               = done_q;
      dmemreq_val        = (state_q == S_REQ);
      dmemreq_msg_rw     = dmemreq_val & is_store_q;
      dmemreq_msg_addr   = dmemreq_val ? {addr_q[31:2], 2'b00} : 32'b0;
      dmemreq_msg_len    = dmemreq_val ? dmem_len(type_q) : LEN_W;
      dmemreq_msg_data   = dmemreq_msg_rw ? st_data : 32'b0;
      dmemresp_rdy       = (state_q == S_WAIT);
      wb_en_Xhl          = (state_q == S_SCATTER);
      wb_addr_Xhl        = wb_en_Xhl ? rd_q : 5'b0;
      wb_subword_off_Xhl = wb_en_Xhl ? cnt_q : '0;
      wb_data_Xhl        = wb_en_Xhl ? data_q[cnt_q*P_NBITS +: P_NBITS] : '0;
   end

endmodule
